// File: rtl/ram_port_a_burst_writer.sv
// Burst write sequencer for RAM port A: one registered write per accepted beat, done/aborted pulses.
// Latency: beat accepted at edge n writes during n->n+1; done high n+1->n+2. data_ready drops on abort.
module ram_port_a_burst_writer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_a,
  input  logic                  reset_a,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_start_address,
  input  logic [ADDR_WIDTH-1:0] cmd_length,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  abort,
  output logic                  write_enable_a,
  output logic                  output_enable_a,
  output logic [ADDR_WIDTH-1:0] address_a,
  output logic [DATA_WIDTH-1:0] data_in_a,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   address_a_q, address_a_d;
  logic [DATA_WIDTH-1:0]   data_in_a_q, data_in_a_d;
  logic                    write_enable_a_q, write_enable_a_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    beat_acc;

  assign cmd_ready  = (state_q == IDLE);
  assign data_ready = (state_q == BURST) && !abort;
  assign beat_acc   = data_valid && data_ready;

  always_comb begin
    state_d          = state_q;
    cur_addr_d       = cur_addr_q;
    remaining_d      = remaining_q;
    address_a_d      = address_a_q;
    data_in_a_d      = data_in_a_q;
    write_enable_a_d = beat_acc;
    done_d           = 1'b0;
    aborted_d        = 1'b0;

    if (beat_acc) begin
      address_a_d = cur_addr_q;
      data_in_a_d = data_in;
      cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_start_address;
          remaining_d = cmd_length;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (beat_acc) begin
          if (remaining_q == '0) begin
            state_d = FINISH;
          end else begin
            remaining_d = remaining_q - ADDR_WIDTH'(1);
          end
        end
      end
      FINISH: begin
        // First cycle lets the last write commit; done rises only once the RAM holds it.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_a or posedge reset_a) begin
    if (reset_a) begin
      state_q          <= IDLE;
      cur_addr_q       <= '0;
      remaining_q      <= '0;
      address_a_q      <= '0;
      data_in_a_q      <= '0;
      write_enable_a_q <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_addr_q       <= cur_addr_d;
      remaining_q      <= remaining_d;
      address_a_q      <= address_a_d;
      data_in_a_q      <= data_in_a_d;
      write_enable_a_q <= write_enable_a_d;
      done_q           <= done_d;
      aborted_q        <= aborted_d;
    end
  end

  assign write_enable_a  = write_enable_a_q;
  assign output_enable_a = 1'b0;
  assign address_a       = address_a_q;
  assign data_in_a       = data_in_a_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign aborted         = aborted_q;

endmodule

// File: doc/ram_port_a_burst_writer.md
# ram_port_a_burst_writer

Single-clock write sequencer that sits directly upstream of port A of `dual_port_ram`. It accepts a burst command (start address, word count) and a valid/ready data stream, and drives `write_enable_a`, `address_a` and `data_in_a` with one registered write per accepted data beat. It produces a completion pulse, so a port-B consumer on its own clock can start reading once the burst has landed.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width; also the width of `cmd_length`.
- `DATA_WIDTH`, default 8: RAM data width.

- `clk_a`  in  1: block clock, the same clock as RAM port A.
- `reset_a`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: burst command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_start_address`  in  ADDR_WIDTH: first RAM address of the burst.
- `cmd_length`  in  ADDR_WIDTH: number of words minus one (0 → 1 word, 255 → 256 words).
- `data_valid`  in  1: write data beat present.
- `data_ready`  out  1: block accepts a beat this cycle.
- `data_in`  in  DATA_WIDTH: write data.
- `abort`  in  1: terminate the current burst.
- `write_enable_a`  out  1: to RAM port A.
- `output_enable_a`  out  1: to RAM port A; constant 0.
- `address_a`  out  ADDR_WIDTH: to RAM port A.
- `data_in_a`  out  DATA_WIDTH: to RAM port A.
- `busy`  out  1: high while not in IDLE.
- `done`  out  1: one-cycle pulse when a burst completes normally.
- `aborted`  out  1: one-cycle pulse when a burst is terminated by `abort`.

## Operation
- FSM states: IDLE, BURST, FINISH.
- **IDLE**
  - `cmd_ready`=1 and `data_ready`=0.
  - When `cmd_valid` is high, latch `cmd_start_address` into `cur_addr` and `cmd_length` into `remaining`, then go to BURST.
- **BURST**
  - `cmd_ready`=0. `data_ready`=1 unless `abort` is high.
  - A beat is accepted when `data_valid`&&`data_ready`. On that edge the registered port-A outputs take `write_enable_a`=1, `address_a`=`cur_addr`, `data_in_a`=`data_in`.
  - After the accepted beat, `cur_addr` increments modulo 2^ADDR_WIDTH, so 255 wraps to 0.
  - If `remaining`==0 on the accepted beat, go to FINISH. Otherwise decrement `remaining`.
  - Cycles with no accepted beat produce `write_enable_a`=0 on the next cycle. `address_a` and `data_in_a` hold their last values.
- **FINISH**
  - Lasts one cycle with `done`=1, then returns to IDLE.
  - `cmd_ready`=0 while in FINISH, so there are no back-to-back command accepts.
- **Abort**
  - `abort` high in BURST forces `data_ready`=0, so no beat is accepted that cycle.
  - The next state is IDLE and `aborted` pulses for one cycle.
  - Writes already issued stand and are not rolled back.
  - `abort` is ignored in IDLE and FINISH.
- `output_enable_a` is permanently 0. This block never reads.
- `busy` = (state != IDLE).

## Timing
- **Reset** (asynchronous, effective immediately):
  - state=IDLE
  - `write_enable_a`=0, `output_enable_a`=0
  - `address_a`=0, `data_in_a`=0
  - `done`=0, `aborted`=0, `busy`=0
  - `cmd_ready`=1, `data_ready`=0
  - internal `cur_addr`=0, `remaining`=0
- **Command to first accept:** a command accepted at edge k allows a beat to be accepted at edge k+1 at the earliest.
- **Write latency:** a beat accepted at edge n drives `write_enable_a`=1 during cycle n→n+1. The RAM commits it at edge n+1.
- **Done timing:** for the final beat accepted at edge n:
  - the last `write_enable_a` is high during n→n+1;
  - `done` is high during n+1→n+2, after which the RAM holds the data;
  - `cmd_ready` returns at n+2.
- **Throughput:** one word per cycle while `data_valid` is held high. An N-word burst with continuous data takes N+2 cycles from command accept to IDLE.
- `cmd_ready` and `data_ready` are combinational from state and `abort`. All RAM-facing outputs are registered.
- **Reset mid-burst:** `write_enable_a` drops immediately, with no `done` or `aborted` pulse. The RAM contents already written are unaffected.
- **`abort` on the same cycle as the final `data_valid`:** abort wins. The beat is not accepted, `aborted` pulses and `done` does not.

## Test plan
- **Single-word burst.** After reset, check all outputs are at their reset values. Send cmd start=0x28, length=0 and data 0xA0 → exactly one `write_enable_a` cycle with addr 0x28 / data 0xA0, `done` one cycle later, then port B reads 0xA0 at 0x28.
- **Five-word continuous burst.** Send start=40, length=4, data 0xA0..0xA4 back-to-back → writes to addresses 40..44 on consecutive cycles, and `done` 6 cycles after command accept. Port B on an independent slow clock (14 ns period) reads 0xA0..0xA4 after `done`.
- **Gapped data.** Deassert `data_valid` for 3 cycles between the beats of a 3-word burst → `write_enable_a` is low during the gaps, addresses remain contiguous, and `remaining` is not consumed by idle cycles.
- **Wrap.** Send start=0xFE, length=3 → writes go to 0xFE, 0xFF, 0x00, 0x01.
- **Abort and reset.**
  - Assert `abort` after the 2nd beat of a 5-word burst → 2 writes only, `aborted` pulses, `done` is never seen, and IDLE is reached the next cycle.
  - Separately, assert `reset_a` mid-burst → `write_enable_a`=0 immediately and `cmd_ready`=1.
